mvm_scheduler: RTL
==================

Name: mvm_scheduler

Overview:
- Sequences and shares one dot_prod matrix-vector engine between N_REQ requesters, such as the four LSTM gate units (input, forget, output, candidate).
- Round-robin arbitrates the requests and steers the weight-memory bank select to the winner.
- Holds the engine in reset between jobs, then releases it for exactly one pass.
- Watches the engine's dataReady and latches the finished output vector. Returns the result to the winner with a one-cycle done pulse.
- Includes a watchdog that aborts a pass if dataReady never arrives.

Parameters:
- N_REQ, 4, number of requesters (≥2).
- NROW, 16, engine rows.
- NCOL, 16, engine columns.
- QN, 6, integer bits.
- QM, 11, fraction bits.
- DSP48_PER_ROW, 2, engine row multiplex factor.
- Derived, not overridable: BITWIDTH=QN+QM+1, LAYER_BITWIDTH=BITWIDTH*NROW, SEL_W=log2(N_REQ), PASS_LEN=NCOL*DSP48_PER_ROW, WD_LIMIT=PASS_LEN+4.

Ports:
- clk, input, 1, system clock; single clock domain.
- reset, input, 1, synchronous, active-low reset.
- req, input, N_REQ, level request per requester.
- grant, output, N_REQ, one-hot owner of the engine; zero when idle.
- done, output, N_REQ, one-cycle pulse to the owner when its result is valid.
- err, output, 1, one-cycle pulse on watchdog abort.
- busy, output, 1, high from grant to done/err inclusive.
- weight_sel, output, SEL_W, binary index of the owner; drives the weight-memory bank mux.
- eng_reset, output, 1, active-high reset to the engine.
- eng_data_ready, input, 1, engine dataReady.
- eng_output_vector, input, LAYER_BITWIDTH, engine outputVector.
- result_vector, output, LAYER_BITWIDTH, latched result.
- result_valid, output, 1, high in the same cycle as the done pulse.

Behaviour:
- Reset (reset=0 at a clk edge):
  - State goes to IDLE.
  - grant=0, done=0, err=0, busy=0, weight_sel=0, result_valid=0, result_vector=0.
  - eng_reset=1.
  - Round-robin pointer goes to requester 0, which gets highest priority first.
  - Reset in any state aborts the pass with no done and no err.
- States: IDLE, RUN, CAPTURE, ABORT.
- IDLE:
  - eng_reset=1.
  - If req≠0, the arbiter picks the first set bit at or after the pointer, wrapping modulo N_REQ.
  - At the next edge: grant=onehot(winner), weight_sel=winner, busy=1, eng_reset=0, watchdog=0, go to RUN.
  - Pointer becomes winner+1, mod N_REQ.
- RUN:
  - eng_reset=0 and the watchdog increments each cycle.
  - Taking edge T as the one where eng_reset falls, the engine spends cycle T in IDLE, runs PASS_LEN CALC cycles, and asserts eng_data_ready during cycle T+1+PASS_LEN.
  - When eng_data_ready=1: latch eng_output_vector into result_vector, set eng_reset=1, go to CAPTURE.
  - When watchdog reaches WD_LIMIT without eng_data_ready: set eng_reset=1, go to ABORT.
- CAPTURE (one cycle):
  - done[owner]=1 and result_valid=1.
  - Next edge: grant=0, busy=0, back to IDLE.
  - The earliest next grant is one cycle later, so eng_reset is high for at least 2 cycles between passes.
- ABORT (one cycle):
  - err=1; done stays 0; result_vector is unchanged.
  - Next edge: grant=0, busy=0, back to IDLE.
- Requests:
  - req is sampled only in IDLE.
  - Deasserting req during RUN does not cancel the pass; done still pulses.
  - A requester must drop req by the cycle after done, otherwise it re-enters arbitration at the lowest priority.
- Timing rules:
  - weight_sel and grant are stable for the whole pass.
  - End-to-end latency, req sampled in IDLE to done: PASS_LEN+3 cycles (35 at defaults).
  - eng_data_ready seen outside RUN is ignored.
  - Simultaneous eng_data_ready and watchdog expiry: data wins and the result goes to CAPTURE.
- Datapath: no arithmetic here. result_vector is a bit-exact copy of the engine output (signed, Q(QN).(QM) per BITWIDTH lane).

Decomposition:
- Package mvm_pkg holds:
  - the log2 function;
  - BITWIDTH/LAYER_BITWIDTH/PASS_LEN derivations;
  - the state encoding localparams (IDLE=0, RUN=1, CAPTURE=2, ABORT=3).
- One sub-module, rr_arbiter:
  - takes N_REQ req, pointer and enable;
  - produces the one-hot winner and the binary index;
  - is purely combinational, with the pointer register living in mvm_scheduler.

Test Plan:
1. Single request:
   - Stimulus: req=0001; engine model with weights 2048 (1.0) and input 1024 (0.5).
   - Expected: grant=0001 next cycle, weight_sel=0, and eng_reset low for exactly PASS_LEN+2 cycles.
   - Expected: done[0] pulses at cycle 35 with every result lane =16384 (8.0).
2. Contention:
   - Stimulus: req=1111 held continuously.
   - Expected: grants in order 0001,0010,0100,1000,0001; each done is followed by eng_reset high ≥2 cycles.
3. Round-robin fairness:
   - Stimulus: req0 re-raised immediately after its done while req2 is pending.
   - Expected: req2 is granted before req0's second pass.
4. Watchdog:
   - Stimulus: tie eng_data_ready=0.
   - Expected: err pulses at cycle WD_LIMIT+2 after grant (38 at defaults) with done=0; result_vector keeps its previous value; IDLE is re-entered.
5. Reset mid-run:
   - Stimulus: reset=0 for one cycle at RUN cycle 10.
   - Expected: next cycle grant=0, busy=0, eng_reset=1, result_vector=0; no done and no err.
6. Request dropped during a pass:
   - Stimulus: req=0100 deasserted at RUN cycle 3.
   - Expected: the pass completes and done[2] pulses at cycle 35.

Source files
------------

// File: rtl/mvm_pkg.sv
// rtl/mvm_pkg.sv - shared types, derivations and helpers for the mvm scheduler
package mvm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CAPTURE = 2'd2,
    ABORT   = 2'd3
  } state_t;

  // Ceiling log2, with a minimum of zero; used for index and counter widths.
  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int calc_bitwidth(input int qn, input int qm);
    return qn + qm + 1;
  endfunction

  function automatic int calc_layer_bitwidth(input int qn, input int qm, input int nrow);
    return calc_bitwidth(qn, qm) * nrow;
  endfunction

  function automatic int calc_pass_len(input int ncol, input int dsp_per_row);
    return ncol * dsp_per_row;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a pointer
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int SEL_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] pointer,
  input  logic             enable,
  output logic [N_REQ-1:0] onehot,
  output logic [SEL_W-1:0] index,
  output logic             valid
);

  function automatic int wrap_idx(input int base, input int offs);
    return (base + offs) % N_REQ;
  endfunction

  // First set bit at or after the pointer wins; later candidates are masked by valid.
  always_comb begin
    onehot = '0;
    index  = '0;
    valid  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (enable && !valid && req[wrap_idx(int'(pointer), i)]) begin
        valid = 1'b1;
        onehot[wrap_idx(int'(pointer), i)] = 1'b1;
        index = SEL_W'(wrap_idx(int'(pointer), i));
      end
    end
  end

endmodule

// File: rtl/mvm_scheduler.sv
// rtl/mvm_scheduler.sv - shares one dot_prod engine among requesters, one pass per grant
module mvm_scheduler
  import mvm_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int NROW          = 16,
  parameter int NCOL          = 16,
  parameter int QN            = 6,
  parameter int QM            = 11,
  parameter int DSP48_PER_ROW = 2,
  localparam int BITWIDTH       = calc_bitwidth(QN, QM),
  localparam int LAYER_BITWIDTH = calc_layer_bitwidth(QN, QM, NROW),
  localparam int SEL_W          = log2(N_REQ),
  localparam int PASS_LEN       = calc_pass_len(NCOL, DSP48_PER_ROW),
  localparam int WD_LIMIT       = PASS_LEN + 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          done,
  output logic                      err,
  output logic                      busy,
  output logic [SEL_W-1:0]          weight_sel,
  output logic                      eng_reset,
  input  logic                      eng_data_ready,
  input  logic [LAYER_BITWIDTH-1:0] eng_output_vector,
  output logic [LAYER_BITWIDTH-1:0] result_vector,
  output logic                      result_valid
);

  localparam int WD_W = log2(WD_LIMIT + 1);

  state_t                    state_q, state_d;
  logic [N_REQ-1:0]          grant_q;
  logic [SEL_W-1:0]          sel_q;
  logic [SEL_W-1:0]          ptr_q;
  logic [WD_W-1:0]           wd_q;
  logic [LAYER_BITWIDTH-1:0] result_q;

  logic [N_REQ-1:0] arb_onehot;
  logic [SEL_W-1:0] arb_index;
  logic             arb_valid;
  logic [SEL_W-1:0] next_ptr;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_arb (
    .req     (req),
    .pointer (ptr_q),
    .enable  (state_q == IDLE),
    .onehot  (arb_onehot),
    .index   (arb_index),
    .valid   (arb_valid)
  );

  // The winner drops to lowest priority for the next arbitration.
  assign next_ptr = (arb_index == SEL_W'(N_REQ - 1)) ? '0 : arb_index + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      sel_q    <= '0;
      ptr_q    <= '0;
      wd_q     <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            grant_q <= arb_onehot;
            sel_q   <= arb_index;
            ptr_q   <= next_ptr;
            wd_q    <= '0;
          end
        end
        RUN: begin
          wd_q <= wd_q + 1'b1;
          if (eng_data_ready) result_q <= eng_output_vector;
        end
        CAPTURE, ABORT: begin
          grant_q <= '0;
        end
        default: begin
          grant_q <= '0;
        end
      endcase
    end
  end

  // Data is checked before the watchdog so a result arriving on the last cycle still counts.
  always_comb begin
    state_d      = state_q;
    done         = '0;
    err          = 1'b0;
    busy         = 1'b1;
    eng_reset    = 1'b1;
    result_valid = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (arb_valid) state_d = RUN;
      end
      RUN: begin
        eng_reset = 1'b0;
        if (eng_data_ready) state_d = CAPTURE;
        else if (wd_q == WD_W'(WD_LIMIT)) state_d = ABORT;
      end
      CAPTURE: begin
        done         = grant_q;
        result_valid = 1'b1;
        state_d      = IDLE;
      end
      ABORT: begin
        err     = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign grant         = grant_q;
  assign weight_sel    = sel_q;
  assign result_vector = result_q;

endmodule
